// File: rtl/execute_pipe_stage.sv
// Y86-64 Execute stage: ALU, condition codes, jXX/cmovXX condition and the E->M pipeline register.
// Results of the instruction presented at a rising edge appear on the outputs after that edge.
module execute_pipe_stage #(
    parameter int unsigned W          = 64,
    parameter int unsigned STACK_STEP = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_icode,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_valA,
    input  logic [W-1:0] in_valB,
    input  logic [W-1:0] in_valC,
    input  logic [3:0]   in_dstE,
    input  logic [3:0]   in_dstM,
    input  logic [2:0]   in_stat,
    input  logic         stall,
    input  logic         bubble,
    input  logic         exc_later,
    output logic [3:0]   out_icode,
    output logic [W-1:0] out_valE,
    output logic [W-1:0] out_valA,
    output logic [3:0]   out_dstE,
    output logic [3:0]   out_dstM,
    output logic         out_cnd,
    output logic [2:0]   out_stat,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_INS    = 3'd4;

    localparam logic [1:0] F_ADD = 2'd0;
    localparam logic [1:0] F_SUB = 2'd1;
    localparam logic [1:0] F_AND = 2'd2;

    localparam logic [W-1:0] POS_STEP = W'(STACK_STEP);
    localparam logic [W-1:0] NEG_STEP = W'(0) - W'(STACK_STEP);

    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic [1:0]   aluFun;
    logic [W-1:0] aluR;
    logic         newZf;
    logic         newSf;
    logic         newOf;
    logic         isCond;
    logic         illegal;
    logic         condTrue;
    logic         cnd;
    logic         ccWrite;
    logic [W-1:0] nextValE;
    logic [3:0]   nextDstE;
    logic [2:0]   nextStat;

    // ALU operand selection
    always_comb begin
        aluA = '0;
        case (in_icode)
            I_RRMOVQ, I_OPQ:               aluA = in_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:  aluA = in_valC;
            I_CALL, I_PUSHQ:               aluA = NEG_STEP;
            I_RET, I_POPQ:                 aluA = POS_STEP;
            default:                       aluA = '0;
        endcase
    end

    always_comb begin
        aluB = '0;
        case (in_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: aluB = in_valB;
            default:                                                   aluB = '0;
        endcase
    end

    assign aluFun = (in_icode == I_OPQ) ? in_ifun[1:0] : F_ADD;

    // ALU and flag generation; sub computes B - A
    always_comb begin
        aluR  = '0;
        newOf = 1'b0;
        case (aluFun)
            F_ADD: begin
                aluR  = aluB + aluA;
                newOf = (aluA[W-1] == aluB[W-1]) && (aluR[W-1] != aluA[W-1]);
            end
            F_SUB: begin
                aluR  = aluB - aluA;
                newOf = (aluA[W-1] != aluB[W-1]) && (aluR[W-1] != aluB[W-1]);
            end
            F_AND:   aluR = aluB & aluA;
            default: aluR = aluB ^ aluA;
        endcase
        newZf = (aluR == '0);
        newSf = aluR[W-1];
    end

    assign isCond  = (in_icode == I_RRMOVQ) || (in_icode == I_JXX);
    assign illegal = ((in_icode == I_OPQ) && (in_ifun > 4'd3)) ||
                     (isCond && (in_ifun > 4'd6));

    // Condition evaluation against the CC contents before any update this cycle
    always_comb begin
        condTrue = 1'b0;
        case (in_ifun)
            4'd0:    condTrue = 1'b1;
            4'd1:    condTrue = (cc_sf ^ cc_of) | cc_zf;
            4'd2:    condTrue = cc_sf ^ cc_of;
            4'd3:    condTrue = cc_zf;
            4'd4:    condTrue = !cc_zf;
            4'd5:    condTrue = !(cc_sf ^ cc_of);
            4'd6:    condTrue = !(cc_sf ^ cc_of) && !cc_zf;
            default: condTrue = 1'b0;
        endcase
    end

    assign cnd      = isCond && !illegal && condTrue;
    assign nextValE = illegal ? '0 : aluR;
    assign nextDstE = ((in_icode == I_RRMOVQ) && !cnd) ? REG_NONE : in_dstE;
    // An incoming non-AOK status is older than the ifun check and keeps priority
    assign nextStat = (in_stat != S_AOK) ? in_stat : (illegal ? S_INS : S_AOK);
    assign ccWrite  = (in_icode == I_OPQ) && (in_ifun <= 4'd3) && (in_stat == S_AOK) &&
                      !stall && !bubble && !exc_later;

    // E->M pipeline register; stall takes priority over bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_icode <= I_NOP;
            out_valE  <= '0;
            out_valA  <= '0;
            out_dstE  <= REG_NONE;
            out_dstM  <= REG_NONE;
            out_cnd   <= 1'b0;
            out_stat  <= S_AOK;
        end else if (stall) begin
            out_icode <= out_icode;
        end else if (bubble) begin
            out_icode <= I_NOP;
            out_valE  <= '0;
            out_valA  <= '0;
            out_dstE  <= REG_NONE;
            out_dstM  <= REG_NONE;
            out_cnd   <= 1'b0;
            out_stat  <= S_AOK;
        end else begin
            out_icode <= in_icode;
            out_valE  <= nextValE;
            out_valA  <= in_valA;
            out_dstE  <= nextDstE;
            out_dstM  <= in_dstM;
            out_cnd   <= cnd;
            out_stat  <= nextStat;
        end
    end

    // Condition-code register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_zf <= 1'b1;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else if (ccWrite) begin
            cc_zf <= newZf;
            cc_sf <= newSf;
            cc_of <= newOf;
        end
    end

endmodule

// File: tb/tb_execute_pipe_stage.sv
// Directed bench for execute_pipe_stage (W=64, STACK_STEP=8) with hand-computed expectations.
module tb_execute_pipe_stage;

    logic        clk;
    logic        rst_n;
    logic [3:0]  inIcode;
    logic [3:0]  inIfun;
    logic [63:0] inValA;
    logic [63:0] inValB;
    logic [63:0] inValC;
    logic [3:0]  inDstE;
    logic [3:0]  inDstM;
    logic [2:0]  inStat;
    logic        stall;
    logic        bubble;
    logic        excLater;
    logic [3:0]  outIcode;
    logic [63:0] outValE;
    logic [63:0] outValA;
    logic [3:0]  outDstE;
    logic [3:0]  outDstM;
    logic        outCnd;
    logic [2:0]  outStat;
    logic        ccZf;
    logic        ccSf;
    logic        ccOf;

    int nCompared;
    int nMismatched;

    execute_pipe_stage #(.W(64), .STACK_STEP(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_icode  (inIcode),
        .in_ifun   (inIfun),
        .in_valA   (inValA),
        .in_valB   (inValB),
        .in_valC   (inValC),
        .in_dstE   (inDstE),
        .in_dstM   (inDstM),
        .in_stat   (inStat),
        .stall     (stall),
        .bubble    (bubble),
        .exc_later (excLater),
        .out_icode (outIcode),
        .out_valE  (outValE),
        .out_valA  (outValA),
        .out_dstE  (outDstE),
        .out_dstM  (outDstM),
        .out_cnd   (outCnd),
        .out_stat  (outStat),
        .cc_zf     (ccZf),
        .cc_sf     (ccSf),
        .cc_of     (ccOf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkCc(input string tag, input logic zf, input logic sf, input logic of);
        checkVal(tag, 64'({ccZf, ccSf, ccOf}), 64'({zf, sf, of}));
    endtask

    // Present one instruction, clock it in, and sample 1 time unit after the edge
    task automatic exec(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                        input logic [3:0] dm, input logic [2:0] st, input logic stl,
                        input logic bub, input logic exc);
        inIcode  = ic;
        inIfun   = fn;
        inValA   = a;
        inValB   = b;
        inValC   = c;
        inDstE   = de;
        inDstM   = dm;
        inStat   = st;
        stall    = stl;
        bubble   = bub;
        excLater = exc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst_n = 1'b0;
        inIcode = 4'h1; inIfun = 4'h0; inValA = '0; inValB = '0; inValC = '0;
        inDstE = 4'hF; inDstM = 4'hF; inStat = 3'd1;
        stall = 1'b0; bubble = 1'b0; excLater = 1'b0;

        #12;
        checkVal("rst_icode", 64'(outIcode), 64'h1);
        checkVal("rst_valE", outValE, 64'h0);
        checkVal("rst_dstE", 64'(outDstE), 64'hF);
        checkVal("rst_dstM", 64'(outDstM), 64'hF);
        checkVal("rst_stat", 64'(outStat), 64'h1);
        checkVal("rst_cnd", 64'(outCnd), 64'h0);
        checkCc("rst_cc", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;

        // add overflow
        exec(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h3, 4'hF, 3'd1, 0, 0, 0);
        checkVal("add_ovf_valE", outValE, 64'h8000_0000_0000_0000);
        checkVal("add_ovf_icode", 64'(outIcode), 64'h6);
        checkVal("add_ovf_dstE", 64'(outDstE), 64'h3);
        checkCc("add_ovf_cc", 1'b0, 1'b1, 1'b1);

        // sub to zero, then conditionals
        exec(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h3, 4'hF, 3'd1, 0, 0, 0);
        checkVal("sub_zero_valE", outValE, 64'h0);
        checkCc("sub_zero_cc", 1'b1, 1'b0, 1'b0);
        exec(4'h2, 4'h4, 64'h55, 64'h0, 64'h0, 4'h4, 4'hF, 3'd1, 0, 0, 0);
        checkVal("cmovne_cnd", 64'(outCnd), 64'h0);
        checkVal("cmovne_dstE", 64'(outDstE), 64'hF);
        checkVal("cmovne_valE", outValE, 64'h55);
        exec(4'h7, 4'h3, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF, 3'd1, 0, 0, 0);
        checkVal("je_cnd", 64'(outCnd), 64'h1);
        exec(4'h2, 4'h1, 64'h66, 64'h0, 64'h0, 4'h4, 4'hF, 3'd1, 0, 0, 0);
        checkVal("cmovle_cnd", 64'(outCnd), 64'h1);
        checkVal("cmovle_dstE", 64'(outDstE), 64'h4);

        // stack and address arithmetic
        exec(4'hA, 4'h0, 64'h9, 64'h100, 64'h0, 4'h4, 4'hF, 3'd1, 0, 0, 0);
        checkVal("pushq_valE", outValE, 64'hF8);
        checkVal("pushq_valA", outValA, 64'h9);
        exec(4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 4'h2, 3'd1, 0, 0, 0);
        checkVal("popq_valE", outValE, 64'h108);
        checkVal("popq_dstM", 64'(outDstM), 64'h2);
        exec(4'h8, 4'h0, 64'h0, 64'h200, 64'h0, 4'h4, 4'hF, 3'd1, 0, 0, 0);
        checkVal("call_valE", outValE, 64'h1F8);
        exec(4'h9, 4'h0, 64'h0, 64'h200, 64'h0, 4'h4, 4'hF, 3'd1, 0, 0, 0);
        checkVal("ret_valE", outValE, 64'h208);
        exec(4'h3, 4'h0, 64'h0, 64'h123, 64'h7, 4'h1, 4'hF, 3'd1, 0, 0, 0);
        checkVal("irmovq_valE", outValE, 64'h7);
        exec(4'h5, 4'h0, 64'h0, 64'h10, 64'h8, 4'hF, 4'h1, 3'd1, 0, 0, 0);
        checkVal("mrmovq_valE", outValE, 64'h18);
        checkCc("stack_cc_kept", 1'b1, 1'b0, 1'b0);

        // stall holds everything, bubble inserts a nop, stall wins over bubble
        exec(4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h3, 4'hF, 3'd1, 1, 0, 0);
        checkVal("stall_icode", 64'(outIcode), 64'h5);
        checkVal("stall_valE", outValE, 64'h18);
        checkCc("stall_cc", 1'b1, 1'b0, 1'b0);
        exec(4'h6, 4'h1, 64'h1, 64'h3, 64'h0, 4'h3, 4'hF, 3'd1, 0, 1, 0);
        checkVal("bubble_icode", 64'(outIcode), 64'h1);
        checkVal("bubble_dstE", 64'(outDstE), 64'hF);
        checkVal("bubble_valE", outValE, 64'h0);
        checkCc("bubble_cc", 1'b1, 1'b0, 1'b0);
        exec(4'h3, 4'h0, 64'h0, 64'h0, 64'h9, 4'h2, 4'hF, 3'd1, 0, 0, 0);
        exec(4'h6, 4'h1, 64'h1, 64'h3, 64'h0, 4'h3, 4'hF, 3'd1, 1, 1, 0);
        checkVal("stallbub_icode", 64'(outIcode), 64'h3);
        checkVal("stallbub_valE", outValE, 64'h9);
        checkCc("stallbub_cc", 1'b1, 1'b0, 1'b0);

        // younger exception suppresses CC update
        exec(4'h6, 4'h3, 64'hF0, 64'h0F, 64'h0, 4'h3, 4'hF, 3'd1, 0, 0, 1);
        checkVal("xor_exc_valE", outValE, 64'hFF);
        checkCc("xor_exc_cc", 1'b1, 1'b0, 1'b0);

        // negative result and signed conditions
        exec(4'h6, 4'h1, 64'h3, 64'h1, 64'h0, 4'h3, 4'hF, 3'd1, 0, 0, 0);
        checkVal("sub_neg_valE", outValE, 64'hFFFF_FFFF_FFFF_FFFE);
        checkCc("sub_neg_cc", 1'b0, 1'b1, 1'b0);
        exec(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 3'd1, 0, 0, 0);
        checkVal("jl_cnd", 64'(outCnd), 64'h1);
        exec(4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 3'd1, 0, 0, 0);
        checkVal("jg_cnd", 64'(outCnd), 64'h0);
        exec(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 3'd1, 0, 0, 0);
        checkVal("jge_cnd", 64'(outCnd), 64'h0);

        // illegal function codes
        exec(4'h6, 4'h5, 64'h1, 64'h1, 64'h0, 4'h3, 4'hF, 3'd1, 0, 0, 0);
        checkVal("ill_opq_stat", 64'(outStat), 64'h4);
        checkVal("ill_opq_valE", outValE, 64'h0);
        checkCc("ill_opq_cc", 1'b0, 1'b1, 1'b0);
        exec(4'h7, 4'h7, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 3'd1, 0, 0, 0);
        checkVal("ill_jxx_stat", 64'(outStat), 64'h4);
        checkVal("ill_jxx_cnd", 64'(outCnd), 64'h0);

        // non-AOK status passes through and blocks CC
        exec(4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'h3, 4'hF, 3'd3, 0, 0, 0);
        checkVal("adr_stat", 64'(outStat), 64'h3);
        checkCc("adr_cc", 1'b0, 1'b1, 1'b0);

        // and to zero, then sub overflow
        exec(4'h6, 4'h2, 64'hF0, 64'h0F, 64'h0, 4'h3, 4'hF, 3'd1, 0, 0, 0);
        checkVal("and_valE", outValE, 64'h0);
        checkCc("and_cc", 1'b1, 1'b0, 1'b0);
        exec(4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 4'h3, 4'hF, 3'd1, 0, 0, 0);
        checkVal("sub_ovf_valE", outValE, 64'h7FFF_FFFF_FFFF_FFFF);
        checkCc("sub_ovf_cc", 1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-operation, then normal capture
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async_rst_icode", 64'(outIcode), 64'h1);
        checkVal("async_rst_valE", outValE, 64'h0);
        checkVal("async_rst_stat", 64'(outStat), 64'h1);
        checkCc("async_rst_cc", 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        exec(4'h3, 4'h0, 64'h0, 64'h0, 64'h33, 4'h5, 4'hF, 3'd1, 0, 0, 0);
        checkVal("post_rst_valE", outValE, 64'h33);
        checkVal("post_rst_icode", 64'(outIcode), 64'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/execute_pipe_stage.md
Name: execute_pipe_stage

Overview:
- Registered Execute stage (E→M pipeline register) for the pipelined Y86-64 processor, parametrised in datapath width.
- Computes ALU result, updates a persistent condition-code register, evaluates the jXX/cmovXX condition `cnd`, and presents all results to the Memory stage one clock later.
- Supports pipeline stall and bubble control, and suppresses CC updates while a younger exception is in flight.

Parameters:
- W, 64, datapath width in bits (≥ 16).
- STACK_STEP, 8, stack-pointer adjustment for call/pushq/ret/popq.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_icode  input  4  Y86 icode from the D→E register.
- in_ifun  input  4  function/condition code.
- in_valA  input  W  operand A.
- in_valB  input  W  operand B.
- in_valC  input  W  immediate/displacement.
- in_dstE  input  4  ALU destination register ID (0xF = none).
- in_dstM  input  4  memory destination register ID.
- in_stat  input  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- stall  input  1  hold the E→M register.
- bubble  input  1  load a nop into the E→M register.
- exc_later  input  1  an exception exists in stage M or W; blocks CC writes.
- out_icode  output  4  registered icode.
- out_valE  output  W  registered ALU result.
- out_valA  output  W  registered pass-through of valA.
- out_dstE  output  4  registered dstE; forced to 0xF on a failed cmov.
- out_dstM  output  4  registered dstM.
- out_cnd  output  1  registered condition result.
- out_stat  output  3  registered status.
- cc_zf, cc_sf, cc_of  output  1 each  current CC register contents.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - out_icode = 1 (nop), out_valE = 0, out_valA = 0.
  - out_dstE = out_dstM = 0xF, out_cnd = 0, out_stat = 1.
  - CC = {ZF=1, SF=0, OF=0}.
  - Reset asserted mid-operation discards in-flight state; the first edge after rst_n releases captures normally.
- ALU operand A:
  - valA for icode 2 and 6.
  - valC for icode 3, 4 and 5.
  - −STACK_STEP for icode 8 and 10.
  - +STACK_STEP for icode 9 and 11.
  - 0 otherwise.
- ALU operand B: valB for icode 4, 5, 6, 8, 9, 10, 11; 0 otherwise.
- ALU function: ifun for icode 6, add for all other icodes.
  - 0 = B+A, 1 = B−A, 2 = B&A, 3 = B^A.
  - Results wrap modulo 2^W.
- Flags from the ALU result R (used only for icode 6):
  - ZF = (R == 0); SF = R[W−1].
  - OF for add: A and B have the same sign and R's sign differs from A's.
  - OF for sub: A and B have different signs and R's sign differs from B's.
  - OF for and/xor: 0.
- CC write occurs at a rising edge only when all hold: icode == 6, ifun ≤ 3, in_stat == AOK, !stall, !bubble, !exc_later.
- Condition evaluation (icode 2 and 7) uses the pre-update CC:
  - ifun 0: always true.
  - ifun 1 (le): (SF^OF) | ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF) & !ZF.
  - For all other icodes, cnd = 0.
- Failed cmov (icode 2, cnd = 0): out_dstE = 0xF.
- Illegal ifun (icode 6 with ifun > 3, or icode 2/7 with ifun > 6):
  - out_stat = 4 (INS), cnd = 0, out_valE = 0.
  - No CC write.
- Latency: inputs present at edge n appear on the outputs after edge n (1 cycle).
- Stall: all output registers and CC hold their values.
- Bubble: output registers load the reset nop values; CC holds.
- stall and bubble asserted together: stall wins.
- in_stat ≠ AOK passes through to out_stat unchanged and blocks the CC write.

Test Plan:
- Reset: assert rst_n=0 between clock edges → outputs change immediately to icode=1, dstE=0xF, stat=1, CC={1,0,0}.
- OPq add overflow, W=64: valA=0x7FFF_FFFF_FFFF_FFFF, valB=1, ifun=0 → after 1 edge: valE=0x8000_0000_0000_0000, CC={ZF0,SF1,OF1}.
- OPq sub then conditional ops:
  - Step 1: sub with valA=5, valB=5 → valE=0, ZF=1.
  - Step 2: cmovne (icode 2, ifun 4) → cnd=0, dstE=0xF.
  - Step 3: je (icode 7, ifun 3) → cnd=1.
- Stack ops:
  - pushq (icode 10), valB=0x100 → valE=0xF8.
  - popq (icode 11), valB=0x100 → valE=0x108.
  - irmovq (icode 3), valC=7 → valE=7.
- Stall/bubble:
  - stall=1 with a new OPq at the input → outputs and CC unchanged.
  - bubble=1 → icode=1, dstE=0xF, CC unchanged.
  - stall=1 and bubble=1 together → outputs hold.
- Suppression and illegal ifun:
  - OPq xor with exc_later=1 → valE is correct but CC is unchanged.
  - OPq with ifun=5 → stat=4, valE=0, CC unchanged.
